// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests and buffers
// returned instructions (with PC and PC+4) in a DEPTH-entry decoupling queue.
module fetch_queue_stage #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       redirect_valid_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  input  logic                       pred_valid_i,
  input  logic [XLEN-1:0]            pred_target_i,
  output logic                       imem_req_valid_o,
  output logic [XLEN-1:0]            imem_req_addr_o,
  input  logic                       imem_req_ready_i,
  input  logic                       imem_rsp_valid_i,
  input  logic [31:0]                imem_rsp_data_i,
  output logic                       instr_valid_o,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            instr_pc_o,
  output logic [XLEN-1:0]            instr_pc_plus4_o,
  input  logic                       instr_ready_i,
  output logic [XLEN-1:0]            pc_f_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Control state (reset)
  logic [XLEN-1:0]  pc_f_p0;
  logic [PTR_W-1:0] alloc_ptr_p0;
  logic [PTR_W-1:0] fill_ptr_p0;
  logic [PTR_W-1:0] head_ptr_p0;
  logic [CNT_W-1:0] count_p0;
  logic [CNT_W-1:0] pend_p0;
  logic [CNT_W-1:0] drop_p0;
  logic [DEPTH-1:0] vld_p0;

  // Queue payload (no reset)
  logic [XLEN-1:0]  ent_pc_p0    [DEPTH];
  logic [XLEN-1:0]  ent_pc4_p0   [DEPTH];
  logic [31:0]      ent_instr_p0 [DEPTH];

  logic             issue;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;
  logic [CNT_W:0]   credit_used;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

  // Stale requests still in flight after a flush: old drops plus every
  // allocated-but-unfilled entry, less a response consumed this very cycle.
  function automatic logic [CNT_W-1:0] drop_after_flush(
    input logic [CNT_W-1:0] drop,
    input logic [CNT_W-1:0] pend,
    input logic             rsp
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, drop} + {1'b0, pend};
    if (rsp && (sum != '0)) sum = sum - (CNT_W+1)'(1);
    return sum[CNT_W-1:0];
  endfunction

  assign credit_used      = {1'b0, count_p0} + {1'b0, drop_p0};
  assign imem_req_valid_o = !redirect_valid_i && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_req_addr_o  = pc_f_p0;
  assign pc_f_o           = pc_f_p0;
  assign count_o          = count_p0;

  assign issue    = imem_req_valid_o && imem_req_ready_i;
  assign pop      = instr_valid_o && instr_ready_i;
  assign rsp_drop = imem_rsp_valid_i && (drop_p0 != '0);
  assign rsp_fill = imem_rsp_valid_i && (drop_p0 == '0) && (pend_p0 != '0);

  assign instr_valid_o    = vld_p0[head_ptr_p0] && !redirect_valid_i;
  assign instr_o          = ent_instr_p0[head_ptr_p0];
  assign instr_pc_o       = ent_pc_p0[head_ptr_p0];
  assign instr_pc_plus4_o = ent_pc4_p0[head_ptr_p0];

  // Control update: redirect flushes everything; otherwise issue, fill and pop
  // act independently on distinct entries.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_f_p0      <= RESET_VECTOR;
      alloc_ptr_p0 <= '0;
      fill_ptr_p0  <= '0;
      head_ptr_p0  <= '0;
      count_p0     <= '0;
      pend_p0      <= '0;
      drop_p0      <= '0;
      vld_p0       <= '0;
    end else if (redirect_valid_i) begin
      pc_f_p0     <= redirect_pc_i;
      fill_ptr_p0 <= alloc_ptr_p0;
      head_ptr_p0 <= alloc_ptr_p0;
      count_p0    <= '0;
      pend_p0     <= '0;
      vld_p0      <= '0;
      drop_p0     <= drop_after_flush(drop_p0, pend_p0, imem_rsp_valid_i);
    end else begin
      if (issue) begin
        pc_f_p0      <= pred_valid_i ? pred_target_i : pc_plus4(pc_f_p0);
        alloc_ptr_p0 <= ptr_inc(alloc_ptr_p0);
      end
      if (rsp_fill) begin
        fill_ptr_p0         <= ptr_inc(fill_ptr_p0);
        vld_p0[fill_ptr_p0] <= 1'b1;
      end
      if (pop) begin
        head_ptr_p0         <= ptr_inc(head_ptr_p0);
        vld_p0[head_ptr_p0] <= 1'b0;
      end
      if (rsp_drop) drop_p0 <= drop_p0 - CNT_W'(1);
      count_p0 <= count_p0 + CNT_W'(issue) - CNT_W'(pop);
      pend_p0  <= pend_p0 + CNT_W'(issue) - CNT_W'(rsp_fill);
    end
  end

  // Payload capture: PC pair at issue, instruction word at fill
  always_ff @(posedge clk_i) begin
    if (issue) begin
      ent_pc_p0[alloc_ptr_p0]  <= pc_f_p0;
      ent_pc4_p0[alloc_ptr_p0] <= pc_plus4(pc_f_p0);
    end
    if (rsp_fill && !redirect_valid_i) begin
      ent_instr_p0[fill_ptr_p0] <= imem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: in-order memory model with variable
// latency, expected fetch stream queued at issue and compared at pop.
module tb_fetch_queue_stage;
  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        pred_valid_i = 1'b0;
  logic [31:0] pred_target_i = '0;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc_plus4_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] pc_f_o;
  logic [2:0]  count_o;

  always #5 clk_i = ~clk_i;

  fetch_queue_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .pred_valid_i(pred_valid_i), .pred_target_i(pred_target_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_pc_plus4_o(instr_pc_plus4_o), .instr_ready_i(instr_ready_i),
    .pc_f_o(pc_f_o), .count_o(count_o)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } mem_t;
  typedef struct { logic [31:0] pc; bit filled; } sb_t;

  mem_t        mem_q[$];
  sb_t         sb_q[$];
  mem_t        cur_rsp;
  bit          cur_rsp_v;
  int          cyc, lat, epoch;
  logic [31:0] exp_pc;
  int          checks, errors;
  bit          want_first;
  logic [31:0] first_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: drive the memory response, check outputs, advance the model.
  task automatic cycle();
    bit exp_rv, exp_iv, iss, pop;
    int stale;
    logic [31:0] p4;
    cur_rsp_v = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      cur_rsp   = mem_q.pop_front();
      cur_rsp_v = 1'b1;
    end
    imem_rsp_valid_i = cur_rsp_v;
    imem_rsp_data_i  = cur_rsp_v ? memf(cur_rsp.addr) : 32'h0;
    #2;
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    if (cur_rsp_v && cur_rsp.epoch != epoch) stale++;
    exp_rv = !redirect_valid_i && (sb_q.size() + stale < DEPTH);
    exp_iv = !redirect_valid_i && (sb_q.size() > 0) && sb_q[0].filled;
    check_eq("pc_f", pc_f_o, exp_pc);
    check_eq("count", count_o, sb_q.size());
    check_eq("req_valid", imem_req_valid_o, exp_rv);
    check_eq("instr_valid", instr_valid_o, exp_iv);
    if (exp_rv) check_eq("req_addr", imem_req_addr_o, exp_pc);
    iss = exp_rv && imem_req_ready_i;
    pop = exp_iv && instr_ready_i;
    if (exp_iv) begin
      p4 = sb_q[0].pc + 32'd4;
      check_eq("instr_pc", instr_pc_o, sb_q[0].pc);
      check_eq("instr_pc4", instr_pc_plus4_o, p4);
      check_eq("instr", instr_o, memf(sb_q[0].pc));
    end
    if (redirect_valid_i) begin
      sb_q.delete();
      epoch++;
      exp_pc = redirect_pc_i;
    end else begin
      if (pop) begin
        if (want_first) begin first_pc = sb_q[0].pc; want_first = 1'b0; end
        void'(sb_q.pop_front());
      end
      if (cur_rsp_v && cur_rsp.epoch == epoch) begin
        for (int i = 0; i < sb_q.size(); i++)
          if (!sb_q[i].filled) begin sb_q[i].filled = 1'b1; break; end
      end
      if (iss) begin
        mem_q.push_back('{addr: exp_pc, epoch: epoch, due: cyc + lat});
        sb_q.push_back('{pc: exp_pc, filled: 1'b0});
        exp_pc = pred_valid_i ? pred_target_i : exp_pc + 32'd4;
      end
    end
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_pc_f"}, pc_f_o, RV);
    check_eq({tag, "_count"}, count_o, 0);
    check_eq({tag, "_instr_valid"}, instr_valid_o, 0);
    check_eq({tag, "_req_valid"}, imem_req_valid_o, 1);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1; epoch = 0; exp_pc = RV;
    want_first = 1'b0; first_pc = 32'hDEAD_BEEF; cur_rsp_v = 1'b0;
    #3;
    reset_checks("reset");
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    // Sequential stream with a 1-cycle memory
    imem_req_ready_i = 1'b1; instr_ready_i = 1'b1;
    repeat (12) cycle();

    // Decode stall fills the queue, then drains in order
    instr_ready_i = 1'b0;
    repeat (8) cycle();
    check_eq("full_count", count_o, DEPTH);
    check_eq("full_req_valid", imem_req_valid_o, 0);
    instr_ready_i = 1'b1;
    repeat (10) cycle();

    // Predicted-taken at 0x8 steers the next request to 0x100
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0; cycle(); redirect_valid_i = 1'b0;
    pred_target_i = 32'h100;
    for (int i = 0; i < 12; i++) begin
      pred_valid_i = (exp_pc == 32'h8);
      cycle();
    end
    pred_valid_i = 1'b0;

    // 3-cycle memory, redirect with requests in flight
    lat = 3;
    begin
      int n = 0;
      while (mem_q.size() < 2 && n < 20) begin cycle(); n++; end
      check_eq("inflight_wait_bound", n < 20, 1);
    end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h200; want_first = 1'b1;
    cycle();
    redirect_valid_i = 1'b0;
    repeat (15) cycle();
    check_eq("first_pc_after_redirect", first_pc, 32'h200);

    // Redirect colliding with a response and a decode pop
    lat = 1;
    repeat (6) cycle();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    check_eq("redir_instr_valid", instr_valid_o, 0);
    check_eq("redir_req_valid", imem_req_valid_o, 0);
    cycle();
    redirect_valid_i = 1'b0;
    check_eq("redir_next_addr", imem_req_addr_o, 32'h200);
    check_eq("redir_count", count_o, 0);
    repeat (8) cycle();

    // PC wrap at the top of the address space, then async reset mid-burst
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8; cycle(); redirect_valid_i = 1'b0;
    repeat (8) cycle();
    reset_n_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    #1;
    reset_checks("midreset");
    sb_q.delete(); mem_q.delete(); cur_rsp_v = 1'b0; epoch++; exp_pc = RV;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
